mt_ckpt: RTL and testbench

Parametrised register map table with branch checkpointing, the successor to the two-wide map table. It renames up to DISPATCH_WIDTH instructions per cycle and tracks operand readiness per physical register, with wakeup from a CDB_WIDTH-wide broadcast bus. Up to CKPT_COUNT branch snapshots support single-cycle mispredict recovery. A retirement map still supports full exception recovery. It sits between decode/freelist and the RS/ROB.

---
 rtl/mt_ckpt_pkg.sv | 23 ++
 rtl/mt_ckpt_alloc.sv | 61 ++++++
 rtl/mt_ckpt.sv | 214 +++++++++++++++++++++
 tb/tb_mt_ckpt.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mt_ckpt_pkg.sv
// Shared definitions for the checkpointing map table: width helpers,
// defaults, lane-slice macro and the map-update source select.
`ifndef MT_CKPT_PKG_SV
`define MT_CKPT_PKG_SV
`define MT_LANE(vec, i, w) vec[(i)*(w) +: (w)]
`endif

package mt_ckpt_pkg;

    localparam int unsigned ZERO_REG_DEF = 31;

    function automatic int unsigned idx_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    typedef enum logic [1:0] {
        MAP_HOLD,
        MAP_DISPATCH,
        MAP_RESTORE,
        MAP_RECOVER
    } map_sel_e;

endpackage

// File: rtl/mt_ckpt_alloc.sv
// Branch checkpoint allocator: free mask, lowest-free pick, release on
// resolve / mispredict squash, full flag.
module mt_ckpt_alloc
    import mt_ckpt_pkg::*;
#(
    parameter  int unsigned CKPT_COUNT = 4,
    localparam int unsigned CK_W       = idx_w(CKPT_COUNT)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  alloc,
    input  logic                  resolve,
    input  logic [CK_W-1:0]       resolve_id,
    input  logic                  mispredict,
    input  logic [CK_W-1:0]       mispredict_id,
    input  logic [CKPT_COUNT-1:0] squash_mask,
    input  logic                  recover,
    output logic [CK_W-1:0]       ckpt_id,
    output logic                  ckpt_full
);

    logic [CKPT_COUNT-1:0] free_q;
    logic [CKPT_COUNT-1:0] free_n;
    logic                  found;

    always_comb begin
        ckpt_id = '0;
        found   = 1'b0;
        for (int unsigned k = 0; k < CKPT_COUNT; k++) begin
            if (!found && free_q[k]) begin
                ckpt_id = CK_W'(k);
                found   = 1'b1;
            end
        end
    end

    assign ckpt_full = ~|free_q;

    // Ids freed this cycle only become visible to the picker next cycle.
    always_comb begin
        free_n = free_q;
        if (alloc)
            free_n[ckpt_id] = 1'b0;
        if (resolve)
            free_n[resolve_id] = 1'b1;
        if (mispredict) begin
            free_n                = free_n | squash_mask;
            free_n[mispredict_id] = 1'b1;
        end
        if (recover)
            free_n = '1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            free_q <= '1;
        else
            free_q <= free_n;
    end

endmodule

// File: rtl/mt_ckpt.sv
// Register map table with intra-group bypass, CDB wakeup, branch snapshots
// for one-cycle mispredict restore and a retirement map for exceptions.
module mt_ckpt
    import mt_ckpt_pkg::*;
#(
    parameter  int unsigned AR_COUNT       = 32,
    parameter  int unsigned PR_COUNT       = 128,
    parameter  int unsigned DISPATCH_WIDTH = 2,
    parameter  int unsigned CDB_WIDTH      = 6,
    parameter  int unsigned CKPT_COUNT     = 4,
    parameter  int unsigned ZERO_REG       = ZERO_REG_DEF,
    localparam int unsigned AR_W           = idx_w(AR_COUNT),
    localparam int unsigned PR_W           = idx_w(PR_COUNT),
    localparam int unsigned CK_W           = idx_w(CKPT_COUNT)
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [DISPATCH_WIDTH-1:0]        id_valid,
    input  logic [DISPATCH_WIDTH-1:0]        id_dest_valid,
    input  logic [DISPATCH_WIDTH*AR_W-1:0]   id_dest_idx,
    input  logic [2*DISPATCH_WIDTH-1:0]      id_src_valid,
    input  logic [2*DISPATCH_WIDTH*AR_W-1:0] id_src_idx,
    input  logic [DISPATCH_WIDTH-1:0]        id_branch,
    input  logic [DISPATCH_WIDTH*PR_W-1:0]   fl_pr,
    input  logic [CDB_WIDTH-1:0]             cdb_broadcast,
    input  logic [CDB_WIDTH*PR_W-1:0]        cdb_pr_tag,
    input  logic                             br_resolve,
    input  logic [CK_W-1:0]                  br_resolve_id,
    input  logic                             br_mispredict,
    input  logic [CK_W-1:0]                  br_mispredict_id,
    input  logic [CKPT_COUNT-1:0]            br_squash_mask,
    input  logic                             recover,
    input  logic [DISPATCH_WIDTH-1:0]        rob_retire_valid,
    input  logic [DISPATCH_WIDTH*AR_W-1:0]   rob_retire_ar,
    input  logic [DISPATCH_WIDTH*PR_W-1:0]   rob_retire_pr,
    output logic [DISPATCH_WIDTH*PR_W-1:0]   rob_told,
    output logic [2*DISPATCH_WIDTH*PR_W-1:0] rs_pr,
    output logic [2*DISPATCH_WIDTH-1:0]      rs_pr_ready,
    output logic [CK_W-1:0]                  ckpt_id,
    output logic                             ckpt_full
);

    localparam logic [AR_W-1:0] ZR = AR_W'(ZERO_REG);

    logic [PR_W-1:0]           map_q        [AR_COUNT];
    logic [PR_W-1:0]           retired_q    [AR_COUNT];
    logic [PR_W-1:0]           snap_q       [CKPT_COUNT][AR_COUNT];
    logic [PR_W-1:0]           map_work     [AR_COUNT];
    logic [PR_W-1:0]           snap_data    [AR_COUNT];
    logic [PR_W-1:0]           retired_work [AR_COUNT];
    logic [PR_COUNT-1:0]       ready_q;
    logic [PR_COUNT-1:0]       ready_n;

    logic [AR_W-1:0]           dest_ar [DISPATCH_WIDTH];
    logic [PR_W-1:0]           new_pr  [DISPATCH_WIDTH];
    logic [DISPATCH_WIDTH-1:0] dest_live;
    logic                      dispatch_ok;
    logic                      snap_take;
    logic                      alloc_br;
    map_sel_e                  map_sel;

    logic [PR_W:0]             hit_src;
    logic [PR_W:0]             hit_dst;
    logic [AR_W-1:0]           sar;

    always_comb begin
        for (int unsigned i = 0; i < DISPATCH_WIDTH; i++) begin
            dest_ar[i]   = `MT_LANE(id_dest_idx, i, AR_W);
            new_pr[i]    = `MT_LANE(fl_pr, i, PR_W);
            dest_live[i] = id_valid[i] && id_dest_valid[i] && (dest_ar[i] != ZR);
        end
    end

    assign dispatch_ok = !recover && !br_mispredict;
    assign alloc_br    = dispatch_ok && snap_take;

    // {bypassed, pr}: youngest older lane writing the same AR overrides the map.
    function automatic logic [PR_W:0] lookup(input logic [AR_W-1:0] ar, input int unsigned lane);
        logic [PR_W:0] r;
        r = {1'b0, map_q[ar]};
        for (int unsigned j = 0; j < lane; j++)
            if (dest_live[j] && dest_ar[j] == ar)
                r = {1'b1, new_pr[j]};
        return r;
    endfunction

    function automatic logic cdb_hit(input logic [PR_W-1:0] pr);
        logic h;
        h = 1'b0;
        for (int unsigned c = 0; c < CDB_WIDTH; c++)
            if (cdb_broadcast[c] && `MT_LANE(cdb_pr_tag, c, PR_W) == pr)
                h = 1'b1;
        return h;
    endfunction

    always_comb begin
        rs_pr       = '0;
        rs_pr_ready = '0;
        rob_told    = '0;
        hit_src     = '0;
        hit_dst     = '0;
        sar         = '0;
        for (int unsigned i = 0; i < DISPATCH_WIDTH; i++) begin
            for (int unsigned s = 0; s < 2; s++) begin
                sar     = `MT_LANE(id_src_idx, 2*i+s, AR_W);
                hit_src = lookup(sar, i);
                `MT_LANE(rs_pr, 2*i+s, PR_W) = hit_src[PR_W-1:0];
                rs_pr_ready[2*i+s] = !id_src_valid[2*i+s] || (sar == ZR) ||
                    (!hit_src[PR_W] && (ready_q[hit_src[PR_W-1:0]] || cdb_hit(hit_src[PR_W-1:0])));
            end
            hit_dst = lookup(dest_ar[i], i);
            `MT_LANE(rob_told, i, PR_W) = hit_dst[PR_W-1:0];
        end
    end

    // Snapshot captures the map as it stands right after the branch lane.
    always_comb begin
        map_work  = map_q;
        snap_data = map_q;
        snap_take = 1'b0;
        for (int unsigned i = 0; i < DISPATCH_WIDTH; i++) begin
            if (dest_live[i])
                map_work[dest_ar[i]] = new_pr[i];
            if (id_valid[i] && id_branch[i]) begin
                snap_take = 1'b1;
                snap_data = map_work;
            end
        end
    end

    always_comb begin
        retired_work = retired_q;
        for (int unsigned i = 0; i < DISPATCH_WIDTH; i++)
            if (rob_retire_valid[i])
                retired_work[`MT_LANE(rob_retire_ar, i, AR_W)] = `MT_LANE(rob_retire_pr, i, PR_W);
    end

    always_comb begin
        if (recover)
            map_sel = MAP_RECOVER;
        else if (br_mispredict)
            map_sel = MAP_RESTORE;
        else if (|id_valid)
            map_sel = MAP_DISPATCH;
        else
            map_sel = MAP_HOLD;
    end

    always_comb begin
        ready_n = ready_q;
        for (int unsigned c = 0; c < CDB_WIDTH; c++)
            if (cdb_broadcast[c])
                ready_n[`MT_LANE(cdb_pr_tag, c, PR_W)] = 1'b1;
        if (dispatch_ok)
            for (int unsigned i = 0; i < DISPATCH_WIDTH; i++)
                if (dest_live[i])
                    ready_n[new_pr[i]] = 1'b0;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned a = 0; a < AR_COUNT; a++)
                map_q[a] <= PR_W'(a);
        end else begin
            case (map_sel)
                MAP_RECOVER:  map_q <= retired_work;
                MAP_RESTORE:  map_q <= snap_q[br_mispredict_id];
                MAP_DISPATCH: map_q <= map_work;
                MAP_HOLD:     map_q <= map_q;
                default:      map_q <= map_q;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned a = 0; a < AR_COUNT; a++)
                retired_q[a] <= PR_W'(a);
        end else begin
            retired_q <= retired_work;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            ready_q <= '1;
        else if (recover)
            ready_q <= '1;
        else
            ready_q <= ready_n;
    end

    always_ff @(posedge clock) begin
        if (alloc_br)
            snap_q[ckpt_id] <= snap_data;
    end

    mt_ckpt_alloc #(
        .CKPT_COUNT (CKPT_COUNT)
    ) u_alloc (
        .clock         (clock),
        .reset         (reset),
        .alloc         (alloc_br),
        .resolve       (br_resolve),
        .resolve_id    (br_resolve_id),
        .mispredict    (br_mispredict),
        .mispredict_id (br_mispredict_id),
        .squash_mask   (br_squash_mask),
        .recover       (recover),
        .ckpt_id       (ckpt_id),
        .ckpt_full     (ckpt_full)
    );

endmodule

// File: tb/tb_mt_ckpt.sv
// Directed bench for mt_ckpt: rename/bypass, wakeup, checkpoints, recovery.
module tb_mt_ckpt;

    localparam int DW = 2, ARW = 5, PRW = 7, CDBW = 6, CKN = 4, CKW = 2;

    logic                  clock = 1'b0;
    logic                  reset = 1'b0;
    logic [DW-1:0]         id_valid, id_dest_valid, id_branch, rob_retire_valid;
    logic [DW*ARW-1:0]     id_dest_idx, rob_retire_ar;
    logic [2*DW-1:0]       id_src_valid;
    logic [2*DW*ARW-1:0]   id_src_idx;
    logic [DW*PRW-1:0]     fl_pr, rob_retire_pr, rob_told;
    logic [CDBW-1:0]       cdb_broadcast;
    logic [CDBW*PRW-1:0]   cdb_pr_tag;
    logic                  br_resolve, br_mispredict, recover;
    logic [CKW-1:0]        br_resolve_id, br_mispredict_id, ckpt_id;
    logic [CKN-1:0]        br_squash_mask;
    logic [2*DW*PRW-1:0]   rs_pr;
    logic [2*DW-1:0]       rs_pr_ready;
    logic                  ckpt_full;

    int checks = 0;
    int fails  = 0;

    always #5 clock = ~clock;

    mt_ckpt #(
        .AR_COUNT       (32),
        .PR_COUNT       (128),
        .DISPATCH_WIDTH (DW),
        .CDB_WIDTH      (CDBW),
        .CKPT_COUNT     (CKN),
        .ZERO_REG       (31)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .id_valid         (id_valid),
        .id_dest_valid    (id_dest_valid),
        .id_dest_idx      (id_dest_idx),
        .id_src_valid     (id_src_valid),
        .id_src_idx       (id_src_idx),
        .id_branch        (id_branch),
        .fl_pr            (fl_pr),
        .cdb_broadcast    (cdb_broadcast),
        .cdb_pr_tag       (cdb_pr_tag),
        .br_resolve       (br_resolve),
        .br_resolve_id    (br_resolve_id),
        .br_mispredict    (br_mispredict),
        .br_mispredict_id (br_mispredict_id),
        .br_squash_mask   (br_squash_mask),
        .recover          (recover),
        .rob_retire_valid (rob_retire_valid),
        .rob_retire_ar    (rob_retire_ar),
        .rob_retire_pr    (rob_retire_pr),
        .rob_told         (rob_told),
        .rs_pr            (rs_pr),
        .rs_pr_ready      (rs_pr_ready),
        .ckpt_id          (ckpt_id),
        .ckpt_full        (ckpt_full)
    );

    // Decode must never hand over a branch while no checkpoint is free.
    always @(negedge clock) begin
        if (reset === 1'b1 && ckpt_full === 1'b1 && (|(id_valid & id_branch)) && !br_mispredict && !recover) begin
            fails++;
            $display("FAIL ckpt_full_branch: branch dispatched while ckpt_full=%0d", ckpt_full);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clr();
        id_valid = '0; id_dest_valid = '0; id_dest_idx = '0; id_src_valid = '0;
        id_src_idx = '0; id_branch = '0; fl_pr = '0; cdb_broadcast = '0; cdb_pr_tag = '0;
        br_resolve = 1'b0; br_resolve_id = '0; br_mispredict = 1'b0; br_mispredict_id = '0;
        br_squash_mask = '0; recover = 1'b0; rob_retire_valid = '0; rob_retire_ar = '0;
        rob_retire_pr = '0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic src(input int lane, input int s, input int ar);
        id_src_valid[2*lane+s] = 1'b1;
        id_src_idx[(2*lane+s)*ARW +: ARW] = ARW'(ar);
    endtask

    task automatic dst(input int lane, input int ar, input int pr);
        id_valid[lane] = 1'b1;
        id_dest_valid[lane] = 1'b1;
        id_dest_idx[lane*ARW +: ARW] = ARW'(ar);
        fl_pr[lane*PRW +: PRW] = PRW'(pr);
    endtask

    task automatic cdb(input int l, input int tag);
        cdb_broadcast[l] = 1'b1;
        cdb_pr_tag[l*PRW +: PRW] = PRW'(tag);
    endtask

    task automatic retire(input int lane, input int ar, input int pr);
        rob_retire_valid[lane] = 1'b1;
        rob_retire_ar[lane*ARW +: ARW] = ARW'(ar);
        rob_retire_pr[lane*PRW +: PRW] = PRW'(pr);
    endtask

    function automatic logic [PRW-1:0] pr_of(input int k);
        return rs_pr[k*PRW +: PRW];
    endfunction

    function automatic logic [PRW-1:0] told_of(input int lane);
        return rob_told[lane*PRW +: PRW];
    endfunction

    task automatic test_reset();
        clr();
        src(0, 0, 5);
        id_dest_idx[1*ARW +: ARW] = 5'd9;
        #2;
        checks++; if (pr_of(0) !== 5) begin fails++; $display("FAIL reset_map got %0d exp 5", pr_of(0)); end
        checks++; if (rs_pr_ready[0] !== 1'b1) begin fails++; $display("FAIL reset_ready got %0b exp 1", rs_pr_ready[0]); end
        checks++; if (told_of(1) !== 9) begin fails++; $display("FAIL reset_told got %0d exp 9", told_of(1)); end
        checks++; if (ckpt_full !== 1'b0) begin fails++; $display("FAIL reset_full got %0b exp 0", ckpt_full); end
        checks++; if (ckpt_id !== 0) begin fails++; $display("FAIL reset_ckpt_id got %0d exp 0", ckpt_id); end
        tick();
    endtask

    task automatic test_rename_bypass();
        clr();
        dst(0, 1, 40);
        dst(1, 1, 41);
        src(1, 0, 1);
        #2;
        checks++; if (pr_of(2) !== 40) begin fails++; $display("FAIL byp_src_pr got %0d exp 40", pr_of(2)); end
        checks++; if (rs_pr_ready[2] !== 1'b0) begin fails++; $display("FAIL byp_src_ready got %0b exp 0", rs_pr_ready[2]); end
        checks++; if (told_of(1) !== 40) begin fails++; $display("FAIL byp_told1 got %0d exp 40", told_of(1)); end
        checks++; if (told_of(0) !== 1) begin fails++; $display("FAIL byp_told0 got %0d exp 1", told_of(0)); end
        tick();
        clr();
        src(0, 0, 1);
        #2;
        checks++; if (pr_of(0) !== 41) begin fails++; $display("FAIL map_r1 got %0d exp 41", pr_of(0)); end
        checks++; if (rs_pr_ready[0] !== 1'b0) begin fails++; $display("FAIL r1_not_ready got %0b exp 0", rs_pr_ready[0]); end
        tick();
    endtask

    task automatic test_cdb_wakeup();
        clr();
        src(1, 1, 1);
        cdb(0, 40);
        #2;
        checks++; if (pr_of(3) !== 41) begin fails++; $display("FAIL cdb_pr got %0d exp 41", pr_of(3)); end
        checks++; if (rs_pr_ready[3] !== 1'b0) begin fails++; $display("FAIL cdb_other_tag got %0b exp 0", rs_pr_ready[3]); end
        cdb(3, 41);
        #1;
        checks++; if (rs_pr_ready[3] !== 1'b1) begin fails++; $display("FAIL cdb_same_cycle got %0b exp 1", rs_pr_ready[3]); end
        tick();
        clr();
        src(0, 0, 1);
        #2;
        checks++; if (rs_pr_ready[0] !== 1'b1) begin fails++; $display("FAIL cdb_table_set got %0b exp 1", rs_pr_ready[0]); end
        tick();
        clr();
        dst(0, 5, 43);
        cdb(5, 43);
        tick();
        clr();
        src(0, 0, 5);
        #2;
        checks++; if (pr_of(0) !== 43) begin fails++; $display("FAIL clr_win_pr got %0d exp 43", pr_of(0)); end
        checks++; if (rs_pr_ready[0] !== 1'b0) begin fails++; $display("FAIL clr_wins got %0b exp 0", rs_pr_ready[0]); end
        tick();
    endtask

    task automatic test_mispredict();
        clr();
        id_valid[0] = 1'b1;
        id_branch[0] = 1'b1;
        dst(1, 2, 50);
        #2;
        checks++; if (ckpt_id !== 0) begin fails++; $display("FAIL mp_alloc_id got %0d exp 0", ckpt_id); end
        tick();
        clr();
        src(0, 0, 2);
        br_mispredict = 1'b1;
        br_mispredict_id = 2'd0;
        dst(1, 6, 55);
        #2;
        checks++; if (pr_of(0) !== 50) begin fails++; $display("FAIL mp_pre_r2 got %0d exp 50", pr_of(0)); end
        checks++; if (ckpt_id !== 1) begin fails++; $display("FAIL mp_next_id got %0d exp 1", ckpt_id); end
        tick();
        clr();
        src(0, 0, 2);
        src(0, 1, 6);
        #2;
        checks++; if (pr_of(0) !== 2) begin fails++; $display("FAIL mp_restore_r2 got %0d exp 2", pr_of(0)); end
        checks++; if (rs_pr_ready[0] !== 1'b1) begin fails++; $display("FAIL mp_r2_ready got %0b exp 1", rs_pr_ready[0]); end
        checks++; if (pr_of(1) !== 6) begin fails++; $display("FAIL mp_dispatch_ignored got %0d exp 6", pr_of(1)); end
        checks++; if (ckpt_id !== 0) begin fails++; $display("FAIL mp_freed_id got %0d exp 0", ckpt_id); end
        checks++; if (ckpt_full !== 1'b0) begin fails++; $display("FAIL mp_full got %0b exp 0", ckpt_full); end
        tick();
        clr();
        dst(0, 7, 70);
        dst(1, 8, 71);
        id_branch[1] = 1'b1;
        tick();
        clr();
        dst(0, 7, 72);
        tick();
        clr();
        br_mispredict = 1'b1;
        br_mispredict_id = 2'd0;
        tick();
        clr();
        src(0, 0, 7);
        src(0, 1, 8);
        #2;
        checks++; if (pr_of(0) !== 70) begin fails++; $display("FAIL snap_r7 got %0d exp 70", pr_of(0)); end
        checks++; if (pr_of(1) !== 71) begin fails++; $display("FAIL snap_r8 got %0d exp 71", pr_of(1)); end
        tick();
    endtask

    task automatic test_ckpt_full();
        for (int k = 0; k < CKN; k++) begin
            clr();
            id_valid[0] = 1'b1;
            id_branch[0] = 1'b1;
            #2;
            checks++; if (ckpt_id !== k) begin fails++; $display("FAIL full_alloc_id got %0d exp %0d", ckpt_id, k); end
            tick();
        end
        clr();
        #2;
        checks++; if (ckpt_full !== 1'b1) begin fails++; $display("FAIL full_set got %0b exp 1", ckpt_full); end
        br_resolve = 1'b1;
        br_resolve_id = 2'd2;
        tick();
        clr();
        #2;
        checks++; if (ckpt_full !== 1'b0) begin fails++; $display("FAIL resolve_full got %0b exp 0", ckpt_full); end
        checks++; if (ckpt_id !== 2) begin fails++; $display("FAIL resolve_id got %0d exp 2", ckpt_id); end
        br_resolve = 1'b1;
        br_resolve_id = 2'd3;
        br_mispredict = 1'b1;
        br_mispredict_id = 2'd0;
        br_squash_mask = 4'b0010;
        tick();
        for (int k = 0; k < CKN; k++) begin
            clr();
            id_valid[0] = 1'b1;
            id_branch[0] = 1'b1;
            #2;
            checks++; if (ckpt_id !== k) begin fails++; $display("FAIL refill_id got %0d exp %0d", ckpt_id, k); end
            tick();
        end
        clr();
        #2;
        checks++; if (ckpt_full !== 1'b1) begin fails++; $display("FAIL refill_full got %0b exp 1", ckpt_full); end
        tick();
    endtask

    task automatic test_recover();
        clr();
        retire(0, 3, 60);
        tick();
        clr();
        dst(0, 3, 61);
        tick();
        clr();
        src(0, 0, 3);
        #2;
        checks++; if (pr_of(0) !== 61) begin fails++; $display("FAIL pre_recover_r3 got %0d exp 61", pr_of(0)); end
        recover = 1'b1;
        retire(1, 9, 65);
        dst(0, 10, 66);
        tick();
        clr();
        src(0, 0, 3);
        src(0, 1, 9);
        src(1, 0, 10);
        src(1, 1, 1);
        #2;
        checks++; if (pr_of(0) !== 60) begin fails++; $display("FAIL rec_r3 got %0d exp 60", pr_of(0)); end
        checks++; if (rs_pr_ready[0] !== 1'b1) begin fails++; $display("FAIL rec_r3_ready got %0b exp 1", rs_pr_ready[0]); end
        checks++; if (pr_of(1) !== 65) begin fails++; $display("FAIL rec_same_cycle_retire got %0d exp 65", pr_of(1)); end
        checks++; if (rs_pr_ready[1] !== 1'b1) begin fails++; $display("FAIL rec_r9_ready got %0b exp 1", rs_pr_ready[1]); end
        checks++; if (pr_of(2) !== 10) begin fails++; $display("FAIL rec_dispatch_ignored got %0d exp 10", pr_of(2)); end
        checks++; if (pr_of(3) !== 1) begin fails++; $display("FAIL rec_r1 got %0d exp 1", pr_of(3)); end
        checks++; if (ckpt_full !== 1'b0) begin fails++; $display("FAIL rec_full got %0b exp 0", ckpt_full); end
        checks++; if (ckpt_id !== 0) begin fails++; $display("FAIL rec_ckpt_id got %0d exp 0", ckpt_id); end
        tick();
    endtask

    task automatic test_zero_and_order();
        clr();
        dst(0, 31, 80);
        src(1, 0, 31);
        #2;
        checks++; if (pr_of(2) !== 31) begin fails++; $display("FAIL zero_no_bypass got %0d exp 31", pr_of(2)); end
        checks++; if (rs_pr_ready[2] !== 1'b1) begin fails++; $display("FAIL zero_ready got %0b exp 1", rs_pr_ready[2]); end
        tick();
        clr();
        src(0, 0, 31);
        #2;
        checks++; if (pr_of(0) !== 31) begin fails++; $display("FAIL zero_map got %0d exp 31", pr_of(0)); end
        tick();
        clr();
        dst(0, 12, 90);
        tick();
        clr();
        src(0, 0, 12);
        id_src_idx[1*ARW +: ARW] = 5'd12;
        #2;
        checks++; if (rs_pr_ready[0] !== 1'b0) begin fails++; $display("FAIL src_valid_notready got %0b exp 0", rs_pr_ready[0]); end
        checks++; if (rs_pr_ready[1] !== 1'b1) begin fails++; $display("FAIL src_invalid_ready got %0b exp 1", rs_pr_ready[1]); end
        tick();
        clr();
        dst(0, 14, 92);
        dst(1, 14, 93);
        #2;
        checks++; if (told_of(1) !== 92) begin fails++; $display("FAIL same_dest_told got %0d exp 92", told_of(1)); end
        tick();
        clr();
        src(0, 0, 14);
        #2;
        checks++; if (pr_of(0) !== 93) begin fails++; $display("FAIL younger_wins got %0d exp 93", pr_of(0)); end
        tick();
    endtask

    task automatic test_reset_midstream();
        clr();
        dst(0, 13, 91);
        id_branch[0] = 1'b1;
        tick();
        clr();
        src(0, 0, 13);
        #2;
        checks++; if (pr_of(0) !== 91) begin fails++; $display("FAIL pre_reset_r13 got %0d exp 91", pr_of(0)); end
        #1 reset = 1'b0;
        #1;
        checks++; if (pr_of(0) !== 13) begin fails++; $display("FAIL async_reset_map got %0d exp 13", pr_of(0)); end
        checks++; if (rs_pr_ready[0] !== 1'b1) begin fails++; $display("FAIL async_reset_ready got %0b exp 1", rs_pr_ready[0]); end
        checks++; if (ckpt_id !== 0) begin fails++; $display("FAIL async_reset_ckpt got %0d exp 0", ckpt_id); end
        tick();
        reset = 1'b1;
        clr();
        src(0, 0, 14);
        #2;
        checks++; if (pr_of(0) !== 14) begin fails++; $display("FAIL post_reset_r14 got %0d exp 14", pr_of(0)); end
        tick();
    endtask

    initial begin
        clr();
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        test_reset();
        test_rename_bypass();
        test_cdb_wakeup();
        test_mispredict();
        test_ckpt_full();
        test_recover();
        test_zero_and_order();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
